// File: rtl/fetch_regfile_unit.sv
// Fetch PC register plus a 32x32 register file with three combinational read ports.
// Register 0 reads as zero; there is no write-to-read bypass.
module fetch_regfile_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        branch_en,
    input  logic [31:0] branch,
    output logic [31:0] pc,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_addr0,
    input  logic [4:0]  read_addr1,
    input  logic [4:0]  read_addr2,
    output logic [31:0] read_data0,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    logic [31:0] pc_next;
    logic [31:0] regs [0:31];

    // The +4 wraps naturally at 2^32; branch targets are taken as-is.
    always_comb begin
        pc_next = pc + 32'd4;
        if (branch_en) begin
            pc_next = branch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

    // Entry 0 is only ever cleared by reset, so it always reads back as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_addr != 5'd0)) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_data0 = regs[read_addr0];
    assign read_data1 = regs[read_addr1];
    assign read_data2 = regs[read_addr2];

endmodule

// File: tb/tb_fetch_regfile_unit.sv
// Directed bench for fetch_regfile_unit: stimulus queues expectations, a monitor
// pops and compares them each time the stimulus raises the sample strobe.
module tb_fetch_regfile_unit;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        branch_en;
    logic [31:0] branch;
    logic [31:0] pc;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr0;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks;
    int failures;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    logic        strobe;

    fetch_regfile_unit #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_en      (pc_en),
        .branch_en  (branch_en),
        .branch     (branch),
        .pc         (pc),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr0 (read_addr0),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data0 (read_data0),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: sel 0 = pc, 1..3 = read_data0..2
    always @(posedge strobe) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          s;
            string       n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            case (s)
                0:       a = pc;
                1:       a = read_data0;
                2:       a = read_data1;
                default: a = read_data2;
            endcase
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    // Driver tasks
    task automatic push_exp(input int sel, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(n);
    endtask

    task automatic sample();
        strobe = 1'b1;
        #1;
        strobe = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        pc_en      = 1'b0;
        branch_en  = 1'b0;
        branch     = '0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        strobe   = 1'b0;
        read_addr0 = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        drive_idle();
        reset = 1'b1;

        // Reset value visible before any clock edge
        #2;
        push_exp(0, 32'hBFC00000, "reset_pc");
        push_exp(1, 32'h0, "reset_rd0");
        push_exp(2, 32'h0, "reset_rd1");
        push_exp(3, 32'h0, "reset_rd2");
        sample();

        // Sequential fetch
        @(negedge clk);
        reset = 1'b0;
        pc_en = 1'b1;
        tick(); push_exp(0, 32'hBFC00004, "seq_pc1"); sample();
        tick(); push_exp(0, 32'hBFC00008, "seq_pc2"); sample();
        tick(); push_exp(0, 32'hBFC0000C, "seq_pc3"); sample();

        // Branch then stall
        @(negedge clk);
        branch_en = 1'b1;
        branch    = 32'h00400020;
        tick(); push_exp(0, 32'h00400020, "branch_pc"); sample();
        @(negedge clk);
        pc_en  = 1'b0;
        branch = 32'h0;
        tick(); push_exp(0, 32'h00400020, "stall_pc1"); sample();
        tick(); push_exp(0, 32'h00400020, "stall_pc2"); sample();

        // PC wrap
        @(negedge clk);
        pc_en     = 1'b1;
        branch    = 32'hFFFFFFFC;
        tick(); push_exp(0, 32'hFFFFFFFC, "wrap_branch"); sample();
        @(negedge clk);
        branch_en = 1'b0;
        tick(); push_exp(0, 32'h00000000, "wrap_pc"); sample();

        // Register write: old value before the edge, new value after
        @(negedge clk);
        pc_en      = 1'b0;
        write_en   = 1'b1;
        write_addr = 5'd2;
        write_data = 32'hDEADBEEF;
        read_addr2 = 5'd2;
        read_addr0 = 5'd2;
        #1;
        push_exp(3, 32'h0, "no_bypass_r2"); sample();
        tick();
        push_exp(3, 32'hDEADBEEF, "write_r2"); push_exp(1, 32'hDEADBEEF, "same_reg_rd0"); sample();
        @(negedge clk);
        write_en   = 1'b0;
        write_data = 32'h11111111;
        tick(); push_exp(3, 32'hDEADBEEF, "write_en_low"); sample();

        // Fetch and register file update on the same edge
        @(negedge clk);
        pc_en      = 1'b1;
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'hCAFEF00D;
        read_addr1 = 5'd3;
        tick();
        push_exp(0, 32'h00000004, "concurrent_pc"); push_exp(2, 32'hCAFEF00D, "concurrent_r3"); sample();

        // r0 hardwire
        @(negedge clk);
        pc_en      = 1'b0;
        write_addr = 5'd0;
        write_data = 32'h12345678;
        read_addr0 = 5'd0;
        tick(); push_exp(1, 32'h0, "r0_hardwire"); sample();

        // Fill r1..r31 with nonzero data
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            write_en   = 1'b1;
            write_addr = 5'(i);
            write_data = 32'h10000000 | 32'(i);
        end
        @(negedge clk);
        write_en   = 1'b0;
        read_addr0 = 5'd1;
        read_addr1 = 5'd16;
        read_addr2 = 5'd31;
        #1;
        push_exp(1, 32'h10000001, "fill_r1");
        push_exp(2, 32'h10000010, "fill_r16");
        push_exp(3, 32'h1000001F, "fill_r31");
        push_exp(0, 32'h00000004, "fill_pc_held");
        sample();

        // Asynchronous reset pulse between edges, with updates requested
        pc_en      = 1'b1;
        branch_en  = 1'b1;
        branch     = 32'h00001000;
        write_en   = 1'b1;
        write_addr = 5'd5;
        write_data = 32'h55555555;
        #1;
        reset = 1'b1;
        #1;
        push_exp(0, 32'hBFC00000, "async_pc");
        push_exp(1, 32'h0, "async_rd0");
        push_exp(2, 32'h0, "async_rd1");
        push_exp(3, 32'h0, "async_rd2");
        sample();
        read_addr2 = 5'd5;
        tick();
        push_exp(0, 32'hBFC00000, "reset_priority_pc");
        push_exp(3, 32'h0, "reset_priority_r5");
        sample();

        // First edge after release behaves normally
        @(negedge clk);
        reset     = 1'b0;
        branch_en = 1'b0;
        tick();
        push_exp(0, 32'hBFC00004, "post_reset_pc");
        push_exp(3, 32'h55555555, "post_reset_r5");
        push_exp(1, 32'h0, "post_reset_r1");
        sample();

        // Bounded drain of any pending expectations
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            sample();
            tick();
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_regfile_unit.md
FETCH_REGFILE_UNIT -- requirements
Module: fetch_regfile_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port pc_en, input, 1 bit: PC update enable.
REQ-005 SHALL have port branch_en, input, 1 bit: selects branch target over sequential PC.
REQ-006 SHALL have port branch, input, 32 bits: branch target address.
REQ-007 SHALL have port pc, output, 32 bits: current instruction address (registered).
REQ-008 SHALL have port write_en, input, 1 bit: register-file write enable.
REQ-009 SHALL have port write_addr, input, 5 bits: register index written.
REQ-010 SHALL have port write_data, input, 32 bits: data written.
REQ-011 SHALL have ports read_addr0, read_addr1 and read_addr2, input, 5 bits each: read port indices.
REQ-012 SHALL have ports read_data0, read_data1 and read_data2, output, 32 bits each: read port data.

Function
REQ-013 SHALL implement the PC as one 32-bit register driving pc directly, with no combinational path from inputs to pc.
REQ-014 SHALL, on a rising clk with pc_en=1 and branch_en=0, load pc+4, with a modulo-2^32 wrap (32'hFFFFFFFC -> 32'h00000000).
REQ-015 SHALL, on a rising clk with pc_en=1 and branch_en=1, load branch unmodified, with no alignment check.
REQ-016 SHALL hold pc when pc_en=0, regardless of branch_en and branch.
REQ-017 SHALL implement 32 registers of 32 bits each, indexed 0-31.
REQ-018 SHALL hardwire register 0 to zero: writes to index 0 are discarded and reads of index 0 return 32'h0.
REQ-019 SHALL, on a rising clk with write_en=1 and write_addr!=0, store write_data into register write_addr.
REQ-020 SHALL make no change to any register when write_en=0.
REQ-021 SHALL read all three ports combinationally and independently: read_dataN = register[read_addrN] with zero-cycle latency.
REQ-022 SHALL provide no write-to-read bypass: a read of the address being written returns the old value until after the clock edge, then the new value.
REQ-023 SHALL allow all three read ports to address the same or different registers simultaneously without interference.
REQ-024 SHALL give fetch and register-file operations no interaction; both may update on the same edge.

Reset
REQ-025 SHALL, while reset=1, immediately (asynchronously) force pc=RESET_VECTOR and all 32 registers to 32'h0.
REQ-026 SHALL give reset priority over pc_en, branch_en and write_en, including reset asserted mid-sequence.
REQ-027 SHALL resume normal operation on the first rising clk after reset deasserts; that edge obeys REQ-014 to REQ-020.
REQ-028 SHALL define every output value from reset: pc=32'hBFC00000 and read_data0/1/2=32'h0.

Verification
REQ-029 SHALL verify reset and sequential fetch: assert reset -> pc=32'hBFC00000 with no clock edge; release, pc_en=1 for 3 edges -> pc=BFC00004, BFC00008, BFC0000C.
REQ-030 SHALL verify branch and stall: pc_en=1, branch_en=1, branch=32'h00400020 -> pc=00400020 next edge; then pc_en=0, branch_en=1, branch=0 -> pc stays 00400020.
REQ-031 SHALL verify PC wrap: branch to 32'hFFFFFFFC, then one sequential edge -> pc=32'h00000000.
REQ-032 SHALL verify register write/read: write 32'hDEADBEEF to r2, read_addr2=2 -> read_data2=DEADBEEF after the edge and old value (0) before it; write_en=0 with other data -> unchanged.
REQ-033 SHALL verify the r0 hardwire: write 32'h12345678 to r0 -> read_data0 with read_addr0=0 stays 32'h0.
REQ-034 SHALL verify reset mid-operation: registers r1..r31 written with nonzero values, async reset pulse between clock edges -> all read ports return 0 and pc=BFC00000 immediately.
